// File: rtl/wb_regfile_pkg.sv
// wb_regfile shared types: EX->WB result bundle and widths.
// Imported by wb_regfile and wb_regfile_rd_port.
package wb_regfile_pkg;

  localparam int N_REG      = 32;
  localparam int N_REG_ADDR = 5;

  localparam logic             RST_ENABLE = 1'b0;
  localparam logic [N_REG-1:0] ZERO_WORD  = '0;

  typedef struct packed {
    logic                  wen;
    logic [N_REG_ADDR-1:0] waddr;
    logic [N_REG-1:0]      wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_regfile_rd_port.sv
// wb_regfile read port: priority mux over reset, enable,
// r0, EX forward, pending WB write and the register array.
module wb_regfile_rd_port
  import wb_regfile_pkg::*;
(
  input  logic                  rst_n,
  input  logic                  re,
  input  logic [N_REG_ADDR-1:0] raddr,
  input  wb_req_t               ex,
  input  wb_req_t               wb,
  input  logic [N_REG-1:0]      arr_data,
  output logic [N_REG-1:0]      rdata
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex.wen && (ex.waddr == raddr);
  assign wb_hit = wb.wen && (wb.waddr == raddr);

  always_comb begin
    rdata = ZERO_WORD;
    if (rst_n == RST_ENABLE) begin
      rdata = ZERO_WORD;
    end else if (!re) begin
      rdata = ZERO_WORD;
    end else if (raddr == '0) begin
      rdata = ZERO_WORD;
    end else if (ex_hit) begin
      rdata = ex.wdata;
    end else if (wb_hit) begin
      rdata = wb.wdata;
    end else begin
      rdata = arr_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: WB stage register, 32x32 GPR array, two bypassed
// read ports. Define WB_REGFILE_EX_FWD_EN to forward EX results.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = N_REG,
  parameter int ADDR_W = N_REG_ADDR,
  parameter int N_REGS = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_wb_wen,
  input  logic [ADDR_W-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_wb_wen,
  output logic [ADDR_W-1:0] o_wb_waddr,
  output logic [DATA_W-1:0] o_wb_wdata
);

  wb_req_t ex_req;
  wb_req_t ex_fwd;
  wb_req_t wb_q;

  logic [DATA_W-1:0] regs [N_REGS];

  assign ex_req.wen   = i_wb_wen;
  assign ex_req.waddr = i_wb_waddr;
  assign ex_req.wdata = i_wb_wdata;

`ifdef WB_REGFILE_EX_FWD_EN
  assign ex_fwd = ex_req;
`else
  assign ex_fwd = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ENABLE) begin
      wb_q <= '0;
    end else if (!i_stall) begin
      wb_q <= ex_req;
    end
  end

  // Commit ignores stall: re-writing a held entry is harmless.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ENABLE) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (wb_q.wen && (wb_q.waddr != '0)) begin
      regs[wb_q.waddr] <= wb_q.wdata;
    end
  end

  assign o_wb_wen   = wb_q.wen;
  assign o_wb_waddr = wb_q.waddr;
  assign o_wb_wdata = wb_q.wdata;

  wb_regfile_rd_port u_rd1 (
    .rst_n    (i_rst_n),
    .re       (i_re1),
    .raddr    (i_raddr1),
    .ex       (ex_fwd),
    .wb       (wb_q),
    .arr_data (regs[i_raddr1]),
    .rdata    (o_rdata1)
  );

  wb_regfile_rd_port u_rd2 (
    .rst_n    (i_rst_n),
    .re       (i_re2),
    .raddr    (i_raddr2),
    .ex       (ex_fwd),
    .wb       (wb_q),
    .arr_data (regs[i_raddr2]),
    .rdata    (o_rdata2)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// wb_regfile bench: directed cases plus random traffic
// checked against an array-based reference model.
module tb_wb_regfile;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_wb_wen;
  logic [4:0]  i_wb_waddr;
  logic [31:0] i_wb_wdata;
  logic        i_re1;
  logic [4:0]  i_raddr1;
  logic [31:0] o_rdata1;
  logic        i_re2;
  logic [4:0]  i_raddr2;
  logic [31:0] o_rdata2;
  logic        o_wb_wen;
  logic [4:0]  o_wb_waddr;
  logic [31:0] o_wb_wdata;

  always #5 i_clk = ~i_clk;

  wb_regfile dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_stall    (i_stall),
    .i_wb_wen   (i_wb_wen),
    .i_wb_waddr (i_wb_waddr),
    .i_wb_wdata (i_wb_wdata),
    .i_re1      (i_re1),
    .i_raddr1   (i_raddr1),
    .o_rdata1   (o_rdata1),
    .i_re2      (i_re2),
    .i_raddr2   (i_raddr2),
    .o_rdata2   (o_rdata2),
    .o_wb_wen   (o_wb_wen),
    .o_wb_waddr (o_wb_waddr),
    .o_wb_wdata (o_wb_wdata)
  );

  int total = 0;
  int bad   = 0;

  // reference model: architectural registers + one pending write
  logic [31:0] m_regs [32];
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic re,
                                         input logic [4:0] a);
    if (!i_rst_n || !re || a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_EX_FWD_EN
    if (i_wb_wen && i_wb_waddr == a) return i_wb_wdata;
`endif
    if (m_wen && m_waddr == a) return m_wdata;
    return m_regs[a];
  endfunction

  task automatic drive(input logic st,
                       input logic wen,
                       input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic re1,
                       input logic [4:0] a1,
                       input logic re2,
                       input logic [4:0] a2);
    @(negedge i_clk);
    i_stall    = st;
    i_wb_wen   = wen;
    i_wb_waddr = wa;
    i_wb_wdata = wd;
    i_re1      = re1;
    i_raddr1   = a1;
    i_re2      = re2;
    i_raddr2   = a2;
    #1;
    chk("wb_wen", {31'b0, o_wb_wen}, {31'b0, m_wen});
    chk("wb_waddr", {27'b0, o_wb_waddr}, {27'b0, m_waddr});
    chk("wb_wdata", o_wb_wdata, m_wdata);
    chk("rdata1", o_rdata1, exp_rd(re1, a1));
    chk("rdata2", o_rdata2, exp_rd(re2, a2));
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_rst_n) begin
      if (m_wen && m_waddr != 5'd0) m_regs[m_waddr] = m_wdata;
      if (!i_stall) begin
        m_wen   = i_wb_wen;
        m_waddr = i_wb_waddr;
        m_wdata = i_wb_wdata;
      end
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_stall    = 1'b0;
    i_wb_wen   = 1'b0;
    i_wb_waddr = '0;
    i_wb_wdata = '0;
    i_re1      = 1'b1;
    i_raddr1   = 5'd1;
    i_re2      = 1'b1;
    i_raddr2   = 5'd2;
    model_clear();
    #2;
    chk("rst_wb_wen", {31'b0, o_wb_wen}, 32'h0);
    chk("rst_rdata1", o_rdata1, 32'h0);
    #5 i_rst_n = 1'b1;

    // basic write then bypass and array read
    drive(0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 5'd3, 1, 5'd3);
    chk("basic_waddr", {27'b0, o_wb_waddr}, 32'd3);
    chk("basic_byp1", o_rdata1, 32'hDEADBEEF);
    chk("basic_byp2", o_rdata2, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 1, 5'd3, 1, 5'd3);
    chk("basic_arr1", o_rdata1, 32'hDEADBEEF);
    tick();

    // r0 stays zero
    drive(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
    tick();
    repeat (3) begin
      drive(0, 0, 0, 0, 1, 5'd0, 1, 5'd0);
      chk("zero_r1", o_rdata1, 32'h0);
      chk("zero_r2", o_rdata2, 32'h0);
      tick();
    end

    // stall holds WB entry
    drive(0, 1, 5'd7, 32'h11, 0, 0, 0, 0);
    tick();
    repeat (3) begin
      drive(1, 1, 5'd7, 32'h22, 1, 5'd7, 0, 0);
      chk("stall_wdata", o_wb_wdata, 32'h11);
`ifndef WB_REGFILE_EX_FWD_EN
      chk("stall_rd", o_rdata1, 32'h11);
`endif
      tick();
    end
    drive(0, 1, 5'd7, 32'h22, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 5'd7, 0, 0);
    chk("stall_rel", o_rdata1, 32'h22);
    tick();

    // read disable vs enabled port
    drive(0, 1, 5'd9, 32'h55, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5'd9, 1, 5'd9);
    chk("re_off", o_rdata1, 32'h0);
    chk("re_on", o_rdata2, 32'h55);
    tick();

    // distance-1 hazard
    drive(0, 1, 5'd4, 32'h77, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 5'd4, 32'hABCD, 1, 5'd4, 0, 0);
`ifdef WB_REGFILE_EX_FWD_EN
    chk("fwd_on", o_rdata1, 32'hABCD);
`else
    chk("fwd_off", o_rdata1, 32'h77);
`endif
    tick();

    // reset with a pending write to r5
    drive(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 5'd5, 1, 5'd5);
    #1 i_rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_wen", {31'b0, o_wb_wen}, 32'h0);
    chk("mid_rst_wdata", o_wb_wdata, 32'h0);
    chk("mid_rst_rd", o_rdata1, 32'h0);
    tick();
    #2 i_rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 5'd5, 1, 5'd3);
    chk("post_rst_r5", o_rdata1, 32'h0);
    chk("post_rst_r3", o_rdata2, 32'h0);
    tick();

    // random traffic over a small address window
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) == 0,
            ($urandom % 3) != 0,
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom % 8) != 0,
            5'($urandom_range(0, 7)),
            ($urandom % 8) != 0,
            5'($urandom_range(0, 7)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the execute-stage result interface. Consumes the EX result triple (wen, waddr, wdata) and registers it in a one-entry write-back (WB) stage.
- Commits the WB entry into a 32x32 general-purpose register file.
- Serves two combinational read ports to the decode stage, with bypass of the pending WB write.
- Sits between the execute stage and the decode stage; it closes the EX -> WB -> regfile -> ID loop.

Parameters:
- DATA_W, 32, register/data width (equals `N_REG)
- ADDR_W, 5, register address width (equals `N_REG_ADDR)
- N_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- i_clk  input  1  single clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_stall  input  1  1 = hold WB stage contents this cycle
- i_wb_wen  input  1  EX result write enable
- i_wb_waddr  input  ADDR_W  EX result destination register
- i_wb_wdata  input  DATA_W  EX result data
- i_re1  input  1  read port 1 enable
- i_raddr1  input  ADDR_W  read port 1 address
- o_rdata1  output  DATA_W  read port 1 data
- i_re2  input  1  read port 2 enable
- i_raddr2  input  ADDR_W  read port 2 address
- o_rdata2  output  DATA_W  read port 2 data
- o_wb_wen  output  1  registered WB stage enable
- o_wb_waddr  output  ADDR_W  registered WB stage address
- o_wb_wdata  output  DATA_W  registered WB stage data

Behaviour:
- Reset:
  - i_rst_n low asynchronously clears the WB stage (o_wb_wen=0, o_wb_waddr=0, o_wb_wdata=0) and all N_REGS registers to 0.
  - o_rdata1 and o_rdata2 are forced to 0 while reset is asserted.
  - A write pending in the WB stage when reset asserts is discarded.
- WB stage:
  - On a rising edge with i_stall=0, it captures i_wb_wen, i_wb_waddr and i_wb_wdata.
  - With i_stall=1 it holds its contents. No bubble is inserted.
  - Latency from EX result to WB stage is 1 cycle.
- Commit:
  - On a rising edge, if o_wb_wen=1 and o_wb_waddr!=0, then regs[o_wb_waddr] <= o_wb_wdata.
  - The commit is independent of i_stall. Re-committing a held entry is idempotent, so a stall causes no corruption.
  - Latency from EX result to the register array is 2 edges.
- Register 0 is hard-wired to zero. Writes to it are ignored; reads of it return 0.
- Read port n (identical for n=1,2), combinational, in priority order:
  1. Reset asserted -> 0
  2. i_ren=0 -> 0
  3. i_raddrn=0 -> 0
  4. [EX forward, if enabled; see Optional Feature]
  5. o_wb_wen=1 and o_wb_waddr==i_raddrn -> o_wb_wdata (pending-write bypass)
  6. otherwise -> regs[i_raddrn]
- Both ports may read the same address in the same cycle; both return identical data.
- A read issued in the same cycle as a commit to that address returns the new value, via the bypass.
- Back-to-back EX writes to the same register: the younger value wins at every observation point.

Optional Feature:
- Macro: WB_REGFILE_EX_FWD_EN.
- Defined:
  - Read priority step 4 is active: i_wb_wen=1 and i_wb_waddr==i_raddrn (nonzero) -> i_wb_wdata.
  - This resolves the distance-1 EX->ID hazard inside the block.
- Undefined:
  - Step 4 is absent. Distance-1 hazards are resolved by the decode stage.
  - i_wb_* feed only the WB stage register.

Decomposition:
- defines.svh / shared package holds:
  - `N_REG, `N_REG_ADDR, `RST_ENABLE (1'b0), `ZERO_WORD
  - typedef struct packed {wen, waddr, wdata} wb_req_t, shared with the EX stage outputs
- One sub-module, wb_regfile_rd_port: the priority read/bypass mux, instantiated twice.
- The register array and WB stage register stay in the top module.

Test Plan:
- Reset clear: pulse i_rst_n low mid-run with a pending WB write to r5=0x1234 -> o_wb_*=0; after release, read r5 returns 0.
- Basic write/read: EX writes r3=0xDEADBEEF -> next cycle o_wb_wen=1, o_wb_waddr=3; both ports reading r3 return 0xDEADBEEF in that cycle (bypass) and the cycle after (array).
- Zero register: EX writes r0=0xFFFFFFFF -> reads of r0 return 0 on both ports in every subsequent cycle.
- Stall hold: write r7=0x11 then i_stall=1 for 3 cycles while EX presents r7=0x22 -> o_wb_wdata stays 0x11 and r7 reads 0x11; after stall release, r7 reads 0x22.
- Read disable and same-address reads: i_re1=0 with r9=0x55 -> o_rdata1=0; with i_re2=1, o_rdata2=0x55.
- Forwarding (macro defined): EX presents r4=0xABCD while ID reads r4 in the same cycle -> o_rdata1=0xABCD. With the macro undefined -> old r4 value.
